jteeprom_master: RTL and testbench
==================================

# jteeprom_master

Serial master that turns parallel EEPROM requests into 93C46-style three-wire frames. It sits directly upstream of the 93C46 EEPROM model, driving its scs/sclk/sdi and reading its sdo. A host (CPU glue or a save-state engine) issues one command at a time with a req/busy/done handshake. The block serialises the frame at a divided bit rate, captures read data, and polls the ready/busy line after programming commands.

## Interface
- DIV, 8: half-period of sclk in clk cycles; legal range 4..255.
- TIMEOUT, 65535: maximum clk cycles spent polling sdo for ready; width 16.
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  1  command request; sampled only when busy=0
- cmd  in  3  0 READ, 1 WRITE, 2 ERASE, 3 EWEN, 4 EWDS, 5 ERAL, 6 WRAL, 7 illegal
- addr  in  6  word address (READ/WRITE/ERASE)
- wdata  in  16  write data (WRITE/WRAL)
- busy  out  1  high from acceptance until the cycle after done
- done  out  1  one-cycle completion pulse
- rdata  out  16  last READ result; holds until the next READ completes
- err  out  1  set with done on timeout or illegal cmd; cleared on next acceptance
- scs  out  1  chip select, active high
- sclk  out  1  serial clock
- sdi  out  1  serial data to EEPROM
- sdo  in  1  serial data / ready (1 = ready) from EEPROM

## Operation
- Reset values: busy=0, done=0, rdata=0, err=0, scs=0, sclk=0, sdi=0. State is IDLE.
- IDLE: when req=1 and busy=0, latch cmd/addr/wdata, clear err, and set busy. cmd 7 goes to FINISH with err=1 and no serial activity.
- Frame, MSB first: start bit 1, 2-bit opcode, 6-bit address field, then optional 16 data bits.
  - READ 10+addr, +16 clocked read bits.
  - WRITE 01+addr+wdata.
  - ERASE 11+addr.
  - EWEN 00+11xxxx.
  - EWDS 00+00xxxx.
  - ERAL 00+10xxxx.
  - WRAL 00+01xxxx+wdata.
  - The x bits are driven 0.
- Pulse count N: 9 for ERASE/EWEN/EWDS/ERAL; 25 for READ/WRITE/WRAL.
- SHIFT state: scs=1 for the whole frame. For each pulse, sdi is updated while sclk=0, sclk is held low DIV cycles, then high DIV cycles. For READ pulses 10..25, sdi=0.
- READ capture: on the clk cycle in which sclk falls after pulses 10..25, shift sdo into rdata LSB. The bit from pulse 10 ends as rdata[15]. rdata updates only at completion; no partial value is visible.
- CSGAP: after the last falling edge, scs=0, sdi=0 for DIV cycles.
- READ/EWEN/EWDS then go to FINISH.
- WRITE/ERASE/ERAL/WRAL go to POLL.
- POLL: scs=1, sclk=0. Sample sdo every clk.
  - sdo=1 goes to FINISH.
  - If the cycle count reaches TIMEOUT, set err=1 and go to FINISH.
- FINISH: scs=0, done=1 for one cycle, then IDLE. busy falls in the cycle after done.
- req while busy is ignored (not queued). req held high at done is re-accepted in the following cycle.
- rst mid-frame aborts at once: scs/sclk/sdi go to 0 asynchronously and no done is produced.

## Timing
- Accept on cycle 0 (req=1 seen): busy=1, scs=1, sdi=1 from cycle 1.
- First sclk rise at cycle 1+DIV. Pulse k rises at 1+DIV+2·DIV·(k-1).
- Frame end (last fall) at 1+2·DIV·N.
- READ done at cycle 1+2·DIV·25+DIV+1. With DIV=8 that is cycle 410.
- EWEN/EWDS done at 1+2·DIV·9+DIV+1.
- POLL starts at 1+2·DIV·N+DIV. The earliest done is 2 cycles later.
- DIV≥4 guarantees the EEPROM sees each sclk level for at least 2 clk and updates sdo before the capture edge.

## Test plan
- EWEN, WRITE addr 0x05 wdata 0xA5C3, poll ready, READ addr 0x05 -> rdata=0xA5C3, err=0, each done a single cycle.
- EWEN frame check -> exactly 9 sclk pulses, sdi bits 1,0,0,1,1,0,0,0,0, scs high only during the frame.
- EWEN, ERAL, READ 0x3F -> rdata=0xFFFF. Then EWEN, WRAL 0x1234, READ 0x00 -> 0x1234.
- TIMEOUT=100, sdo forced 0, ERASE -> done with err=1 exactly 100 POLL cycles after POLL entry.
- cmd=7 -> done 2 cycles after acceptance, err=1, scs never rises. A req pulse during a READ frame -> ignored.
- rst asserted at pulse 12 of a READ -> scs=sclk=sdi=0 immediately, busy=0, no done, rdata unchanged at 0. A fresh READ after release completes normally.

Source files
------------

// File: rtl/jteeprom_master.sv
// jteeprom_master: turns one parallel EEPROM request into a 93C46-style
// three-wire frame, captures READ data and polls ready after programming.
module jteeprom_master #(
    parameter int unsigned DIV     = 8,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  cmd,
    input  logic [5:0]  addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        scs,
    output logic        sclk,
    output logic        sdi,
    input  logic        sdo
);
    localparam int unsigned DIV_W = 8;
    localparam int unsigned TO_W  = 16;
    localparam int unsigned PAY_W = 24;  // opcode + address field + data, start bit excluded
    localparam int unsigned PLS_W = 5;

    localparam logic [2:0] CMD_READ  = 3'd0;
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_ERASE = 3'd2;
    localparam logic [2:0] CMD_EWEN  = 3'd3;
    localparam logic [2:0] CMD_EWDS  = 3'd4;
    localparam logic [2:0] CMD_ERAL  = 3'd5;
    localparam logic [2:0] CMD_WRAL  = 3'd6;

    typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CSGAP, S_POLL, S_FINISH} state_t;

    state_t             state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [PAY_W-1:0]   frame_q, frame_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [PLS_W-1:0]   pulse_q, pulse_d;
    logic [TO_W-1:0]    tmo_q, tmo_d;
    logic [15:0]        rsh_q, rsh_d;
    logic               fail_q, fail_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               scs_q, scs_d;
    logic               sclk_q, sclk_d;
    logic               sdi_q, sdi_d;

    logic               is_read, is_long, is_poll;
    logic [PLS_W-1:0]   last_pulse;
    logic [1:0]         op_c;
    logic [5:0]         fld_c;
    logic [15:0]        dat_c;

    // Properties of the latched command.
    assign is_read    = (cmd_q == CMD_READ);
    assign is_long    = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE) || (cmd_q == CMD_WRAL);
    assign is_poll    = (cmd_q == CMD_WRITE) || (cmd_q == CMD_ERASE) ||
                        (cmd_q == CMD_ERAL)  || (cmd_q == CMD_WRAL);
    assign last_pulse = is_long ? PLS_W'(24) : PLS_W'(8);

    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign scs   = scs_q;
    assign sclk  = sclk_q;
    assign sdi   = sdi_q;

    // Frame payload for the incoming command (opcode, address field, data).
    always_comb begin
        op_c  = 2'b00;
        fld_c = addr;
        dat_c = 16'h0000;
        case (cmd)
            CMD_READ:  op_c = 2'b10;
            CMD_WRITE: begin op_c = 2'b01; dat_c = wdata; end
            CMD_ERASE: op_c = 2'b11;
            CMD_EWEN:  fld_c = 6'b110000;
            CMD_EWDS:  fld_c = 6'b000000;
            CMD_ERAL:  fld_c = 6'b100000;
            CMD_WRAL:  begin fld_c = 6'b010000; dat_c = wdata; end
            default:   fld_c = 6'b000000;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        frame_d = frame_q;
        div_d   = div_q;
        pulse_d = pulse_q;
        tmo_d   = tmo_q;
        rsh_d   = rsh_q;
        fail_d  = fail_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        scs_d   = scs_q;
        sclk_d  = sclk_q;
        sdi_d   = sdi_q;
        case (state_q)
            S_IDLE: begin
                if (req && !busy_q) begin
                    cmd_d   = cmd;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    div_d   = '0;
                    pulse_d = '0;
                    tmo_d   = '0;
                    if (cmd == 3'd7) begin
                        fail_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        fail_d  = 1'b0;
                        frame_d = {op_c, fld_c, dat_c};
                        scs_d   = 1'b1;
                        sclk_d  = 1'b0;
                        sdi_d   = 1'b1;
                        state_d = S_SHIFT;
                    end
                end else if (done_q) begin
                    busy_d = 1'b0;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_W'(DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d = 1'b0;
                        if (is_read && (pulse_q >= PLS_W'(9))) begin
                            rsh_d = {rsh_q[14:0], sdo};
                        end
                        if (pulse_q == last_pulse) begin
                            scs_d   = 1'b0;
                            sdi_d   = 1'b0;
                            state_d = S_CSGAP;
                        end else begin
                            pulse_d = pulse_q + PLS_W'(1);
                            sdi_d   = frame_q[PAY_W-1];
                            frame_d = {frame_q[PAY_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_CSGAP: begin
                if (div_q == DIV_W'(DIV - 1)) begin
                    div_d = '0;
                    if (is_poll) begin
                        scs_d   = 1'b1;
                        state_d = S_POLL;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_POLL: begin
                if (sdo) begin
                    scs_d   = 1'b0;
                    state_d = S_FINISH;
                end else if (tmo_q == TO_W'(TIMEOUT - 2)) begin
                    fail_d  = 1'b1;
                    scs_d   = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                err_d   = fail_q;
                state_d = S_IDLE;
                if (is_read && !fail_q) begin
                    rdata_d = rsh_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset drops the serial lines immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            frame_q <= '0;
            div_q   <= '0;
            pulse_q <= '0;
            tmo_q   <= '0;
            rsh_q   <= '0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            scs_q   <= 1'b0;
            sclk_q  <= 1'b0;
            sdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            frame_q <= frame_d;
            div_q   <= div_d;
            pulse_q <= pulse_d;
            tmo_q   <= tmo_d;
            rsh_q   <= rsh_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            scs_q   <= scs_d;
            sclk_q  <= sclk_d;
            sdi_q   <= sdi_d;
        end
    end
endmodule

// File: tb/tb_jteeprom_master.sv
// tb_jteeprom_master: drives jteeprom_master against a small 93C46 model and
// checks timing, frames and data against a command-level memory model.
module tb_jteeprom_master;
    localparam int DIV = 8;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  cmd = '0;
    logic [5:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        busy, done, err, scs, sclk, sdi, sdo;
    logic [15:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // command-level reference: contents and write-enable state
    logic [15:0] ref_mem [64];
    bit          ref_ewen = 1'b0;

    // serial EEPROM model state
    logic [15:0] ee_mem [64];
    bit          ee_ewen = 1'b0;
    bit          ee_loaded = 1'b0;
    int          ee_cnt = 0, ee_busy = 0, ee_last_busy = 0, ee_last_cnt = 0;
    logic [24:0] ee_bits = '0, ee_last_bits = '0;
    logic [1:0]  ee_op = '0;
    logic [5:0]  ee_addr = '0;
    logic        sdo_r = 1'b1, p_sclk = 1'b0, p_scs = 1'b0;
    bit          force_busy = 1'b0;

    // results of the last run_cmd
    int   r_dcyc, r_scs, r_rises;
    bit   r_early;
    logic r_err1, r_done_nx, r_busy_at, r_busy_nx;

    jteeprom_master #(.DIV(DIV), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err),
        .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo)
    );

    always #5 clk = ~clk;

    assign sdo = force_busy ? 1'b0 : sdo_r;

    // 93C46 model: shifts sdi on sclk rise, drives read bits, busy after programming.
    always @(negedge clk) begin : ee_model
        logic [24:0] nb;
        int          nc;
        int          b;
        logic [15:0] w;
        if (rst) begin
            if (!ee_loaded) begin
                for (int i = 0; i < 64; i++) ee_mem[i] <= ref_mem[i];
                ee_loaded <= 1'b1;
            end
            ee_cnt  <= 0;
            ee_bits <= '0;
            ee_busy <= 0;
            sdo_r   <= 1'b1;
            p_sclk  <= 1'b0;
            p_scs   <= 1'b0;
        end else begin
            nb = ee_bits;
            nc = ee_cnt;
            p_sclk <= sclk;
            p_scs  <= scs;
            if (ee_busy > 0) begin
                ee_busy <= ee_busy - 1;
                if (ee_busy == 1) sdo_r <= 1'b1;
            end
            if (scs && !p_scs) begin
                nb = '0;
                nc = 0;
            end
            if (scs && sclk && !p_sclk) begin
                nb = {nb[23:0], sdi};
                nc = nc + 1;
                if (nc == 9) begin
                    ee_op   <= nb[7:6];
                    ee_addr <= nb[5:0];
                end
                if (nc >= 10 && nc <= 25 && ee_op == 2'b10) begin
                    w = ee_mem[ee_addr];
                    sdo_r <= w[25 - nc];
                end
            end
            if (!scs && p_scs && nc > 0) begin
                b = 0;
                case (ee_op)
                    2'b10: sdo_r <= 1'b1;
                    2'b01: if (ee_ewen && nc == 25) begin
                        ee_mem[ee_addr] <= nb[15:0];
                        b = $urandom_range(0, 60);
                    end
                    2'b11: if (ee_ewen) begin
                        ee_mem[ee_addr] <= 16'hFFFF;
                        b = $urandom_range(0, 60);
                    end
                    default: case (ee_addr[5:4])
                        2'b11: ee_ewen <= 1'b1;
                        2'b00: ee_ewen <= 1'b0;
                        2'b10: if (ee_ewen) begin
                            for (int i = 0; i < 64; i++) ee_mem[i] <= 16'hFFFF;
                            b = $urandom_range(0, 60);
                        end
                        default: if (ee_ewen && nc == 25) begin
                            for (int i = 0; i < 64; i++) ee_mem[i] <= nb[15:0];
                            b = $urandom_range(0, 60);
                        end
                    endcase
                endcase
                ee_busy      <= b;
                ee_last_busy <= b;
                if (b > 0) sdo_r <= 1'b0;
                ee_last_bits <= nb;
                ee_last_cnt  <= nc;
                nc = 0;
            end
            ee_bits <= nb;
            ee_cnt  <= nc;
        end
    end

    // Command semantics at the word level.
    task automatic ref_apply(input logic [2:0] c, input logic [5:0] a, input logic [15:0] d);
        case (c)
            3'd1: if (ref_ewen) ref_mem[a] = d;
            3'd2: if (ref_ewen) ref_mem[a] = 16'hFFFF;
            3'd3: ref_ewen = 1'b1;
            3'd4: ref_ewen = 1'b0;
            3'd5: if (ref_ewen) for (int i = 0; i < 64; i++) ref_mem[i] = 16'hFFFF;
            3'd6: if (ref_ewen) for (int i = 0; i < 64; i++) ref_mem[i] = d;
            default: ;
        endcase
    endtask

    // Cycle of done counted from acceptance (cycle 0), from the frame timing rules.
    function automatic int exp_done(input logic [2:0] c, input int b);
        int n, f, p;
        n = (c == 3'd0 || c == 3'd1 || c == 3'd6) ? 25 : 9;
        f = 1 + 2 * DIV * n;
        p = f + DIV;
        if (c == 3'd7) return 2;
        if (c == 3'd0 || c == 3'd3 || c == 3'd4) return p + 1;
        return ((f + b > p) ? f + b : p) + 2;
    endfunction

    // Issue one command from a negedge and wait (bounded) for done.
    task automatic run_cmd(input logic [2:0] c, input logic [5:0] a, input logic [15:0] d,
                           input bit hold, input int pulse_at);
        logic [15:0] rd0;
        logic        ps;
        rd0 = rdata;
        ps  = 1'b0;
        cmd = c; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        r_dcyc = -1; r_scs = 0; r_rises = 0; r_early = 1'b0; r_err1 = 1'bx;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n == 1) r_err1 = err;
            if (pulse_at > 0 && n == pulse_at) begin cmd = 3'd4; req = 1'b1; end
            if (pulse_at > 0 && n == pulse_at + 1) req = 1'b0;
            if (scs) r_scs++;
            if (sclk && !ps) r_rises++;
            ps = sclk;
            if (done) begin r_dcyc = n; break; end
            if (rdata !== rd0) r_early = 1'b1;
        end
        r_busy_at = busy;
        @(negedge clk);
        r_done_nx = done;
        r_busy_nx = busy;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_tests++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0000", rdata); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
        n_tests++; if ({scs, sclk, sdi} !== 3'b000) begin n_fail++; $display("FAIL rst_serial: got %b expected 000", {scs, sclk, sdi}); end
    endtask

    task automatic test_rst_abort();
        logic [5:0] a;
        bit         seen;
        a = 6'($urandom);
        cmd = 3'd0; addr = a; req = 1'b1;
        @(posedge clk); #1; req = 1'b0;
        for (int n = 1; n <= 185; n++) @(negedge clk);
        n_tests++; if ({scs, sclk} !== 2'b11) begin n_fail++; $display("FAIL pulse12_high: got %b expected 11", {scs, sclk}); end
        rst = 1'b1; #1;
        n_tests++; if ({scs, sclk, sdi, busy} !== 4'b0000) begin n_fail++; $display("FAIL abort_lines: got %b expected 0000", {scs, sclk, sdi, busy}); end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (done) seen = 1'b1; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (done || busy) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", seen); end
        n_tests++; if (rdata !== 16'h0) begin n_fail++; $display("FAIL abort_rdata: got %h expected 0000", rdata); end
        run_cmd(3'd0, a, 16'h0, 1'b0, 0);
        n_tests++; if (r_dcyc !== 410) begin n_fail++; $display("FAIL read_done_cycle: got %0d expected 410", r_dcyc); end
        n_tests++; if (rdata !== ref_mem[a]) begin n_fail++; $display("FAIL read_after_rst: got %h expected %h", rdata, ref_mem[a]); end
    endtask

    task automatic test_ewen_frame();
        run_cmd(3'd3, 6'h15, 16'hFFFF, 1'b0, 0);
        ref_apply(3'd3, 6'h15, 16'hFFFF);
        n_tests++; if (r_dcyc !== exp_done(3'd3, 0)) begin n_fail++; $display("FAIL ewen_done_cycle: got %0d expected %0d", r_dcyc, exp_done(3'd3, 0)); end
        n_tests++; if (r_rises !== 9) begin n_fail++; $display("FAIL ewen_pulses: got %0d expected 9", r_rises); end
        n_tests++; if (ee_last_cnt !== 9 || ee_last_bits[8:0] !== 9'b100110000) begin n_fail++; $display("FAIL ewen_bits: got %0d/%b expected 9/100110000", ee_last_cnt, ee_last_bits[8:0]); end
        n_tests++; if (r_scs !== 2 * DIV * 9) begin n_fail++; $display("FAIL ewen_scs_cycles: got %0d expected %0d", r_scs, 2 * DIV * 9); end
        n_tests++; if ({r_busy_at, r_done_nx, r_busy_nx, err} !== 4'b1000) begin n_fail++; $display("FAIL ewen_handshake: got %b expected 1000", {r_busy_at, r_done_nx, r_busy_nx, err}); end
    endtask

    task automatic test_write_read();
        run_cmd(3'd1, 6'h05, 16'hA5C3, 1'b0, 0);
        ref_apply(3'd1, 6'h05, 16'hA5C3);
        n_tests++; if (r_dcyc !== exp_done(3'd1, ee_last_busy)) begin n_fail++; $display("FAIL write_done_cycle: got %0d expected %0d", r_dcyc, exp_done(3'd1, ee_last_busy)); end
        n_tests++; if ({err, r_done_nx} !== 2'b00) begin n_fail++; $display("FAIL write_err_pulse: got %b expected 00", {err, r_done_nx}); end
        run_cmd(3'd0, 6'h05, 16'h0, 1'b0, 0);
        n_tests++; if (rdata !== 16'hA5C3) begin n_fail++; $display("FAIL read_a5c3: got %h expected a5c3", rdata); end
        n_tests++; if ({r_early, err, r_done_nx} !== 3'b000) begin n_fail++; $display("FAIL read_flags: got %b expected 000", {r_early, err, r_done_nx}); end
    endtask

    task automatic test_eral_wral();
        run_cmd(3'd3, 6'h0, 16'h0, 1'b0, 0); ref_apply(3'd3, 6'h0, 16'h0);
        run_cmd(3'd5, 6'h0, 16'h0, 1'b0, 0); ref_apply(3'd5, 6'h0, 16'h0);
        n_tests++; if (r_dcyc !== exp_done(3'd5, ee_last_busy)) begin n_fail++; $display("FAIL eral_done_cycle: got %0d expected %0d", r_dcyc, exp_done(3'd5, ee_last_busy)); end
        run_cmd(3'd0, 6'h3F, 16'h0, 1'b0, 0);
        n_tests++; if (rdata !== 16'hFFFF) begin n_fail++; $display("FAIL eral_read: got %h expected ffff", rdata); end
        run_cmd(3'd3, 6'h0, 16'h0, 1'b0, 0); ref_apply(3'd3, 6'h0, 16'h0);
        run_cmd(3'd6, 6'h0, 16'h1234, 1'b0, 0); ref_apply(3'd6, 6'h0, 16'h1234);
        n_tests++; if (r_dcyc !== exp_done(3'd6, ee_last_busy)) begin n_fail++; $display("FAIL wral_done_cycle: got %0d expected %0d", r_dcyc, exp_done(3'd6, ee_last_busy)); end
        run_cmd(3'd0, 6'h00, 16'h0, 1'b0, 0);
        n_tests++; if (rdata !== 16'h1234) begin n_fail++; $display("FAIL wral_read: got %h expected 1234", rdata); end
    endtask

    task automatic test_timeout();
        logic [5:0] a;
        a = 6'($urandom);
        force_busy = 1'b1;
        run_cmd(3'd2, a, 16'h0, 1'b0, 0);
        force_busy = 1'b0;
        ref_apply(3'd2, a, 16'h0);
        n_tests++; if (r_dcyc !== 1 + 2 * DIV * 9 + DIV + TMO) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", r_dcyc, 1 + 2 * DIV * 9 + DIV + TMO); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", err); end
        run_cmd(3'd0, a, 16'h0, 1'b0, 0);
        n_tests++; if (rdata !== ref_mem[a]) begin n_fail++; $display("FAIL erase_read: got %h expected %h", rdata, ref_mem[a]); end
    endtask

    task automatic test_illegal();
        run_cmd(3'd7, 6'h2A, 16'h0, 1'b0, 0);
        n_tests++; if (r_dcyc !== 2) begin n_fail++; $display("FAIL illegal_done_cycle: got %0d expected 2", r_dcyc); end
        n_tests++; if ({err, r_scs == 0} !== 2'b11) begin n_fail++; $display("FAIL illegal_err_scs: got err=%b scs_cycles=%0d expected 1/0", err, r_scs); end
    endtask

    task automatic test_ignore();
        logic [5:0] a;
        bit         again;
        a = 6'($urandom);
        run_cmd(3'd0, a, 16'h0, 1'b0, 50);
        n_tests++; if (r_err1 !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", r_err1); end
        n_tests++; if (r_dcyc !== 410 || rdata !== ref_mem[a]) begin n_fail++; $display("FAIL ignore_read: got %0d/%h expected 410/%h", r_dcyc, rdata, ref_mem[a]); end
        again = 1'b0;
        repeat (6) begin @(negedge clk); if (busy || scs) again = 1'b1; end
        n_tests++; if (again !== 1'b0) begin n_fail++; $display("FAIL ignore_queued: got %b expected 0", again); end
    endtask

    task automatic test_back_to_back();
        int n2;
        run_cmd(3'd4, 6'h0, 16'h0, 1'b1, 0);
        ref_apply(3'd4, 6'h0, 16'h0);
        n_tests++; if (r_busy_nx !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_drop: got %b expected 0", r_busy_nx); end
        @(negedge clk);
        n_tests++; if ({busy, scs, sdi} !== 3'b111) begin n_fail++; $display("FAIL b2b_reaccept: got %b expected 111", {busy, scs, sdi}); end
        req = 1'b0;
        n2 = -1;
        for (int n = 2; n <= 400; n++) begin
            @(negedge clk);
            if (done) begin n2 = n; break; end
        end
        ref_apply(3'd4, 6'h0, 16'h0);
        n_tests++; if (n2 !== exp_done(3'd4, 0)) begin n_fail++; $display("FAIL b2b_done_cycle: got %0d expected %0d", n2, exp_done(3'd4, 0)); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0]  c;
        logic [5:0]  a;
        logic [15:0] d;
        for (int it = 0; it < 16; it++) begin
            c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) c = 3'd3;
            a = 6'($urandom);
            d = 16'($urandom);
            run_cmd(c, a, d, 1'b0, 0);
            ref_apply(c, a, d);
            n_tests++; if (r_dcyc !== exp_done(c, ee_last_busy)) begin n_fail++; $display("FAIL rnd_done_cycle cmd=%0d: got %0d expected %0d", c, r_dcyc, exp_done(c, ee_last_busy)); end
            n_tests++; if (err !== (c == 3'd7)) begin n_fail++; $display("FAIL rnd_err cmd=%0d: got %b expected %b", c, err, c == 3'd7); end
            if (c == 3'd0) begin
                n_tests++; if (rdata !== ref_mem[a]) begin n_fail++; $display("FAIL rnd_read addr=%0h: got %h expected %h", a, rdata, ref_mem[a]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 16'($urandom);
        test_reset();
        test_rst_abort();
        test_ewen_frame();
        test_write_read();
        test_eral_wral();
        test_timeout();
        test_illegal();
        test_ignore();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
